// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell used by the serial adder datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit pair per cycle, LSB first, through a single full-adder cell.
// Optional two's-complement overflow output enabled by macro SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fa_sum, fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   full_adder u_full_adder (
      .a     (a_q[0]),
      .b     (b_q[0]),
      .c_in  (carry_q),
      .sum   (fa_sum),
      .c_out (fa_cout)
   );

   // State and datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Next-state and datapath update; busy/done are registered from the next state
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = c_in;
               cnt_d   = '0;
               state_d = ADD;
               busy_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = 1'b0;
`endif
            end
         end
         ADD: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
            carry_d = fa_cout;
            cnt_d   = CNT_W'(cnt_q + 1'b1);
            busy_d  = 1'b1;
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q is the carry into the MSB during the last bit
               ovf_d   = carry_q ^ fa_cout;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign c_out = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8), ovf checks when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

   localparam int unsigned WIDTH = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

   int checks   = 0;
   int failures = 0;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One full addition; operands are scrambled after acceptance, optional stray start mid-ADD
   task automatic run_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo, input bit glitch);
      a     = ta;
      b     = tb_v;
      c_in  = tc;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = ~ta;
      b     = ~tb_v;
      c_in  = ~tc;
      for (int i = 0; i < int'(WIDTH); i++) begin
         check("busy_in_add", 32'(busy), 32'd1);
         check("done_in_add", 32'(done), 32'd0);
         if (glitch && i == 3) begin
            start = 1'b1;
            a     = 8'h11;
            b     = 8'h22;
            c_in  = 1'b0;
         end
         tick();
         start = 1'b0;
      end
      check("done_pulse", 32'(done), 32'd1);
      check("busy_in_done", 32'(busy), 32'd0);
      check("sum", 32'(sum), 32'(es));
      check("c_out", 32'(c_out), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf", 32'(ovf), 32'(eo));
`else
      if (eo === 1'bx) $display("note: unexpected X ovf expectation");
`endif
      tick();
      check("done_single", 32'(done), 32'd0);
      check("sum_hold", 32'(sum), 32'(es));
      check("c_out_hold", 32'(c_out), 32'(ec));
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      c_in  = 1'b0;
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_c_out", 32'(c_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      reset = 1'b0;
      tick();

      run_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
      run_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
      run_add(8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 1'b0, 1'b0);
      run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      run_add(8'h96, 8'h2B, 1'b1, 8'hC2, 1'b0, 1'b0, 1'b1);

      // Reset wins over start in the same cycle
      a     = 8'h12;
      b     = 8'h34;
      start = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      check("rst_vs_start_busy", 32'(busy), 32'd0);
      tick();
      check("rst_vs_start_idle", 32'(busy), 32'd0);
      check("rst_vs_start_done", 32'(done), 32'd0);

      // Reset during ADD aborts the addition
      a     = 8'hA5;
      b     = 8'h5A;
      c_in  = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_c_out", 32'(c_out), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("abort_no_done", 32'(done), 32'd0);
         tick();
      end
      run_add(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0, 1'b0);

      // Start held high: one result every WIDTH+2 cycles
      a     = 8'h12;
      b     = 8'h34;
      c_in  = 1'b1;
      start = 1'b1;
      tick();
      for (int cyc = 0; cyc < 30; cyc++) begin
         check("b2b_busy", 32'(busy), ((cyc % 10) < 8) ? 32'd1 : 32'd0);
         check("b2b_done", 32'(done), ((cyc % 10) == 8) ? 32'd1 : 32'd0);
         if ((cyc % 10) == 8) begin
            check("b2b_sum", 32'(sum), 32'h47);
            check("b2b_c_out", 32'(c_out), 32'd0);
         end
         if (cyc == 29) start = 1'b0;
         tick();
      end
      check("b2b_stopped", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_adder
